vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Scan sequencer for the SVGA 800x600@72 Hz display (50 MHz pixel clock).
//  Walks H/V counters, issues one coord_t pixel request per active pixel to the
//  renderer, re-aligns hsync/vsync/de with the renderer's rgb_t reply, and
//  flags the vertical-blank window in which game logic updates its state.
// PARAMETERS
//  H_ACTIVE  800  visible pixels/line (= project::SCREEN_WIDTH)
//  H_FP      56   horizontal front porch, pixels
//  H_SYNC    120  hsync width, pixels
//  H_BP      64   horizontal back porch, pixels
//  V_ACTIVE  600  visible lines (= project::SCREEN_HEIGHT)
//  V_FP      37   vertical front porch, lines
//  V_SYNC    6    vsync width, lines
//  V_BP      23   vertical back porch, lines
//  SYNC_POL  1    asserted level of hsync/vsync (1 = positive)
//  PIPE_LAT  2    renderer latency, cycles from req_* to matching pix_in (>=0)
// PORTS
//  clk          in   1   pixel clock, 50 MHz
//  rst_n        in   1   async active-low reset
//  req_valid    out  1   current cycle is an active pixel; renderer must answer
//  req_coord    out  coord_t  {y,x} of requested pixel; 0 when !req_valid
//  pix_in       in   rgb_t    renderer colour, valid PIPE_LAT cycles after req
//  rgb_out      out  rgb_t    colour to DAC; 0 whenever de=0
//  hsync        out  1   horizontal sync, level SYNC_POL when asserted
//  vsync        out  1   vertical sync, level SYNC_POL when asserted
//  de           out  1   display enable, aligned with rgb_out
//  frame_tick   out  1   1-cycle pulse at start of vertical front porch
//  vblank       out  1   high for all lines vcnt >= V_ACTIVE
// BEHAVIOUR
//  Asynchronous, active-low reset; all state updates on rising clk.
//  - Counters: hcnt 0..H_TOTAL-1 (H_TOTAL=1040, 11 bits), vcnt 0..V_TOTAL-1
//    (V_TOTAL=666, 10 bits). hcnt increments every cycle; at H_TOTAL-1 wraps
//    to 0 and vcnt increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
//  - Explicit H phase FSM ACTIVE->FP->SYNC->BP->ACTIVE, transitions at hcnt =
//    H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, 0. V phase FSM same shape
//    on vcnt, advancing only on the hcnt wrap cycle. Phases must agree with
//    counters every cycle (assertion in bench).
//  - req_valid = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE), decoded from registers,
//    no glitches. req_coord.x = hcnt[9:0], .y = vcnt[9:0] when valid, else 0.
//  - Raw hs = H phase SYNC, vs = V phase SYNC, de_raw = req_valid. These pass
//    through a PIPE_LAT-deep delay line, then one output register, so
//    hsync/vsync/de/rgb_out change PIPE_LAT+1 cycles after the counter state
//    that produced them. rgb_out <= delayed de ? pix_in : 0.
//  - Pixel request for counter state in cycle k: pix_in sampled in cycle
//    k+PIPE_LAT; rgb_out/de visible in cycle k+PIPE_LAT+1.
//  - frame_tick: registered, high for exactly the cycle after (hcnt=0,
//    vcnt=V_ACTIVE) is reached; once per frame. vblank: registered, tracks
//    vcnt>=V_ACTIVE with 1-cycle lag; not pipeline-delayed.
//  - Reset values: hcnt=vcnt=0, phases ACTIVE, delay line cleared to inactive
//    (de=0, syncs deasserted), rgb_out=0, hsync=vsync=!SYNC_POL, frame_tick=0,
//    vblank=0. req_valid=1 with coord (0,0) while in reset (decode of 0,0).
//  - Reset mid-frame: outputs go to reset values immediately (async); scan
//    restarts at (0,0) on first edge after release; no partial pipeline data
//    may appear on rgb_out (cleared de gates it).
//  - Renderer is never stalled; no backpressure exists.
// TESTING
//  1 Reset, release, PIPE_LAT=2 -> req (0,0) cycle 0; de=1 and rgb_out=pix_in
//    of cycle 2 first visible cycle 3; hsync=vsync=0 until sync regions.
//  2 Line timing -> req_valid high 800 cycles, low 240; hsync high for
//    120 cycles starting 3 cycles after hcnt=856; line period 1040.
//  3 Frame timing -> vsync high lines 637..642 (6 lines x 1040 cycles);
//    frame period exactly 692640 cycles; vcnt wraps 665->0 with hcnt 1039->0.
//  4 Drive pix_in=24'hFFFFFF constantly -> rgb_out=0 every cycle de=0.
//  5 frame_tick -> exactly one pulse per frame, cycle after (0,600); vblank
//    high 66 lines; rising edge coincident with frame_tick.
//  6 Assert rst_n=0 at (400,300) for 5 cycles -> de/rgb_out=0, syncs inactive
//    asynchronously; after release req_coord=(0,0), next frame timing intact.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: SVGA scan sequencer issuing pixel requests and realigning sync/de with renderer replies
package project;
  localparam int SCREEN_WIDTH = 800;
  localparam int SCREEN_HEIGHT = 600;
  typedef struct packed {logic [9:0] y; logic [9:0] x;} coord_t;
  typedef struct packed {logic [7:0] r; logic [7:0] g; logic [7:0] b;} rgb_t;
endpackage

module vga_timing_ctrl
  import project::*;
#(
  parameter int H_ACTIVE = SCREEN_WIDTH,
  parameter int H_FP = 56,
  parameter int H_SYNC = 120,
  parameter int H_BP = 64,
  parameter int V_ACTIVE = SCREEN_HEIGHT,
  parameter int V_FP = 37,
  parameter int V_SYNC = 6,
  parameter int V_BP = 23,
  parameter bit SYNC_POL = 1'b1,
  parameter int PIPE_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  output logic   req_valid,
  output coord_t req_coord,
  input  rgb_t   pix_in,
  output rgb_t   rgb_out,
  output logic   hsync,
  output logic   vsync,
  output logic   de,
  output logic   frame_tick,
  output logic   vblank
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;
  logic [10:0] hcnt, hcnt_nx;
  logic [9:0] vcnt, vcnt_nx;
  phase_t h_ph, h_ph_nx, v_ph, v_ph_nx;
  logic h_wrap;
  logic [2:0] raw, dly_out;
  always_comb begin
    h_wrap = hcnt == 11'(H_TOTAL - 1);
    hcnt_nx = h_wrap ? '0 : hcnt + 11'd1;
    vcnt_nx = !h_wrap ? vcnt : (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
    h_ph_nx = h_ph;
    case (h_ph)
      ACT:  if (hcnt_nx == 11'(H_ACTIVE)) h_ph_nx = FP;
      FP:   if (hcnt_nx == 11'(H_ACTIVE + H_FP)) h_ph_nx = SYNC;
      SYNC: if (hcnt_nx == 11'(H_ACTIVE + H_FP + H_SYNC)) h_ph_nx = BP;
      BP:   if (hcnt_nx == '0) h_ph_nx = ACT;
    endcase
    v_ph_nx = v_ph;
    if (h_wrap)
      case (v_ph)
        ACT:  if (vcnt_nx == 10'(V_ACTIVE)) v_ph_nx = FP;
        FP:   if (vcnt_nx == 10'(V_ACTIVE + V_FP)) v_ph_nx = SYNC;
        SYNC: if (vcnt_nx == 10'(V_ACTIVE + V_FP + V_SYNC)) v_ph_nx = BP;
        BP:   if (vcnt_nx == '0) v_ph_nx = ACT;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      h_ph <= ACT;
      v_ph <= ACT;
    end else begin
      hcnt <= hcnt_nx;
      vcnt <= vcnt_nx;
      h_ph <= h_ph_nx;
      v_ph <= v_ph_nx;
    end
  // Decoded only from phase registers so the request strobe is a clean flop-to-output path
  assign req_valid = (h_ph == ACT) && (v_ph == ACT);
  assign req_coord = req_valid ? coord_t'{y: vcnt, x: hcnt[9:0]} : '0;
  assign raw = {h_ph == SYNC, v_ph == SYNC, req_valid};
  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign dly_out = raw;
    end else begin : g_dly
      logic [2:0] sr [PIPE_LAT];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
        end else begin
          sr[0] <= raw;
          for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
        end
      assign dly_out = sr[PIPE_LAT-1];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      de <= 1'b0;
      rgb_out <= '0;
      frame_tick <= 1'b0;
      vblank <= 1'b0;
    end else begin
      hsync <= dly_out[2] ? SYNC_POL : ~SYNC_POL;
      vsync <= dly_out[1] ? SYNC_POL : ~SYNC_POL;
      de <= dly_out[0];
      rgb_out <= dly_out[0] ? pix_in : '0;
      frame_tick <= (hcnt == '0) && (vcnt == 10'(V_ACTIVE));
      vblank <= vcnt >= 10'(V_ACTIVE);
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed vectors and a cycle model on a shrunken raster (16x9 totals)
module tb_vga_timing_ctrl;
  import project::*;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VA = 4, VF = 2, VS = 2, VB = 1, VT = 9;
  localparam int LAT = 2;
  logic clk = 0, rst_n = 0;
  logic req_valid, hsync, vsync, de, frame_tick, vblank;
  coord_t req_coord;
  rgb_t pix_in = '0, rgb_out;
  int cmp = 0, err = 0;
  int ft_cnt, ft_first, ft_last;
  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_coord(req_coord),
    .pix_in(pix_in), .rgb_out(rgb_out), .hsync(hsync), .vsync(vsync),
    .de(de), .frame_tick(frame_tick), .vblank(vblank)
  );
  always #5 clk = ~clk;
  typedef struct {
    int c; bit req; int x; int y; bit de; bit hs; bit vs; bit ft; bit vb; logic [23:0] rgb;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int hh(int s); return s % HT; endfunction
  function automatic int vv(int s); return (s / HT) % VT; endfunction
  function automatic logic [23:0] pix(int c); return 24'hC00000 | 24'(c); endfunction
  // Phase registers must track the counters on every cycle
  always @(negedge clk) begin
    automatic int h = int'(dut.hcnt), v = int'(dut.vcnt);
    chk("h_phase", 32'(dut.h_ph), h < HA ? 0 : h < HA + HF ? 1 : h < HA + HF + HS ? 2 : 3);
    chk("v_phase", 32'(dut.v_ph), v < VA ? 0 : v < VA + VF ? 1 : v < VA + VF + VS ? 2 : 3);
  end
  task automatic sweep(input int n, input bit use_tbl);
    for (int c = 0; c < n; c++) begin
      automatic bit er = hh(c) < HA && vv(c) < VA;
      automatic int s = c - LAT - 1;
      automatic bit ed = s >= 0 && hh(s) < HA && vv(s) < VA;
      automatic bit ehs = s >= 0 && hh(s) >= HA + HF && hh(s) < HA + HF + HS;
      automatic bit evs = s >= 0 && vv(s) >= VA + VF && vv(s) < VA + VF + VS;
      automatic bit eft = c >= 1 && hh(c - 1) == 0 && vv(c - 1) == VA;
      automatic bit evb = c >= 1 && vv(c - 1) >= VA;
      chk($sformatf("req_valid@%0d", c), 32'(req_valid), 32'(er));
      chk($sformatf("coord_x@%0d", c), 32'(req_coord.x), er ? hh(c) : 0);
      chk($sformatf("coord_y@%0d", c), 32'(req_coord.y), er ? vv(c) : 0);
      chk($sformatf("de@%0d", c), 32'(de), 32'(ed));
      chk($sformatf("hsync@%0d", c), 32'(hsync), 32'(ehs));
      chk($sformatf("vsync@%0d", c), 32'(vsync), 32'(evs));
      chk($sformatf("rgb@%0d", c), 32'(rgb_out), ed ? 32'(pix(c - 1)) : 0);
      chk($sformatf("frame_tick@%0d", c), 32'(frame_tick), 32'(eft));
      chk($sformatf("vblank@%0d", c), 32'(vblank), 32'(evb));
      if (frame_tick) begin
        if (ft_cnt == 0) ft_first = c;
        ft_last = c;
        ft_cnt++;
      end
      if (use_tbl)
        for (int i = 0; i < 16; i++)
          if (tbl[i].c == c) begin
            chk($sformatf("tbl%0d_req", i), 32'(req_valid), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_x", i), 32'(req_coord.x), tbl[i].x);
            chk($sformatf("tbl%0d_y", i), 32'(req_coord.y), tbl[i].y);
            chk($sformatf("tbl%0d_de", i), 32'(de), 32'(tbl[i].de));
            chk($sformatf("tbl%0d_hs", i), 32'(hsync), 32'(tbl[i].hs));
            chk($sformatf("tbl%0d_vs", i), 32'(vsync), 32'(tbl[i].vs));
            chk($sformatf("tbl%0d_ft", i), 32'(frame_tick), 32'(tbl[i].ft));
            chk($sformatf("tbl%0d_vb", i), 32'(vblank), 32'(tbl[i].vb));
            chk($sformatf("tbl%0d_rgb", i), 32'(rgb_out), 32'(tbl[i].rgb));
          end
      pix_in = pix(c);
      @(negedge clk);
    end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_req"}, 32'(req_valid), 1);
    chk({nm, "_coord"}, 32'(req_coord), 0);
    chk({nm, "_de"}, 32'(de), 0);
    chk({nm, "_rgb"}, 32'(rgb_out), 0);
    chk({nm, "_hsync"}, 32'(hsync), 0);
    chk({nm, "_vsync"}, 32'(vsync), 0);
    chk({nm, "_ft"}, 32'(frame_tick), 0);
    chk({nm, "_vb"}, 32'(vblank), 0);
  endtask
  initial begin
    tbl[0]  = '{0,   1, 0, 0, 0, 0, 0, 0, 0, 24'h0};
    tbl[1]  = '{3,   1, 3, 0, 1, 0, 0, 0, 0, 24'hC00002};
    tbl[2]  = '{8,   0, 0, 0, 1, 0, 0, 0, 0, 24'hC00007};
    tbl[3]  = '{11,  0, 0, 0, 0, 0, 0, 0, 0, 24'h0};
    tbl[4]  = '{13,  0, 0, 0, 0, 1, 0, 0, 0, 24'h0};
    tbl[5]  = '{16,  1, 0, 1, 0, 0, 0, 0, 0, 24'h0};
    tbl[6]  = '{19,  1, 3, 1, 1, 0, 0, 0, 0, 24'hC00012};
    tbl[7]  = '{64,  0, 0, 0, 0, 0, 0, 0, 0, 24'h0};
    tbl[8]  = '{65,  0, 0, 0, 0, 0, 0, 1, 1, 24'h0};
    tbl[9]  = '{66,  0, 0, 0, 0, 0, 0, 0, 1, 24'h0};
    tbl[10] = '{98,  0, 0, 0, 0, 0, 0, 0, 1, 24'h0};
    tbl[11] = '{99,  0, 0, 0, 0, 0, 1, 0, 1, 24'h0};
    tbl[12] = '{130, 0, 0, 0, 0, 0, 1, 0, 1, 24'h0};
    tbl[13] = '{131, 0, 0, 0, 0, 0, 0, 0, 1, 24'h0};
    tbl[14] = '{144, 1, 0, 0, 0, 0, 0, 0, 1, 24'h0};
    tbl[15] = '{145, 1, 1, 0, 0, 0, 0, 0, 0, 24'h0};
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1;
    ft_cnt = 0; ft_first = 0; ft_last = 0;
    sweep(2 * HT * VT + 2 * HT + 4, 1);
    chk("ft_count", 32'(ft_cnt), 2);
    chk("frame_period", 32'(ft_last - ft_first), HT * VT);
    chk("pre_reset_de", 32'(de), 1);
    rst_n = 0;
    #1;
    chk_reset("async_rst");
    repeat (5) @(negedge clk);
    chk_reset("held_rst");
    rst_n = 1;
    ft_cnt = 0; ft_first = 0; ft_last = 0;
    sweep(HT * VT + 2, 0);
    chk("ft_after_rst", 32'(ft_cnt), 1);
    chk("ft_pos_after_rst", 32'(ft_first), HT * VA + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
